// File: rtl/mips_bus_controller.sv
// -----------------------------------------------------------------------------
// mips_bus_controller
//
// Multi-cycle sequencer for the bus variant of the MIPS CPU. A single
// Avalon-style memory port carries both instruction fetches and load/store
// data. The datapath is stepped through FETCH -> EXEC -> MEM -> WB. The
// module generates the gating strobes for pc, instruction register, register
// file and load-data register. It also drives the bus request handshake,
// detects the halt address, and flags a bus timeout.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   clk_enable     in   1 = advance, 0 = freeze FSM (strobes forced low)
//   waitrequest    in   memory stall; transfer completes when request && !waitrequest
//   pc             in   current PC (fetch address)
//   is_load        in   decoder: load instruction (sampled in EXEC)
//   is_store       in   decoder: store instruction (sampled in EXEC)
//   active         out  CPU running
//   mem_read       out  bus read request
//   mem_write      out  bus write request
//   addr_sel       out  bus address mux: 0 = pc, 1 = ALU result
//   ir_write       out  latch instruction register (1-cycle pulse)
//   pc_write       out  PC update strobe (1-cycle pulse)
//   reg_write_gate out  allow register-file write this cycle
//   data_latch     out  latch load data register (1-cycle pulse)
//   bus_error      out  sticky timeout flag
//   state          out  FSM state (debug)
// -----------------------------------------------------------------------------
module mips_bus_controller #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int          WAIT_W    = 8,
    parameter int          MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        waitrequest,
    input  logic [31:0] pc,
    input  logic        is_load,
    input  logic        is_store,
    output logic        active,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write_gate,
    output logic        data_latch,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              store_q, store_d;   // MEM transfer kind: 1 = write, 0 = read

    logic              fetch_req;
    logic              bus_req;
    logic              timeout;

    // A fetch is requested only when the PC is not the halt address.
    assign fetch_req = (state_q == S_FETCH) && (pc != HALT_ADDR);
    assign bus_req   = fetch_req || (state_q == S_MEM);

    // The stall that would be number MAX_WAIT+1 trips the timeout.
    assign timeout   = (MAX_WAIT != 0) && bus_req && waitrequest &&
                       (wait_cnt_q == WAIT_W'(MAX_WAIT));

    assign state = state_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            store_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            store_q    <= store_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        wait_cnt_d = wait_cnt_q;

        if (clk_enable) begin
            unique case (state_q)
                S_FETCH: begin
                    if (pc == HALT_ADDR)   state_d = S_HALTED;
                    else if (!waitrequest) state_d = S_EXEC;
                    else if (timeout)      state_d = S_ERROR;
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                        // If both flags are set, the instruction is treated as a load.
                        store_d = is_store && !is_load;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    if (!waitrequest) state_d = store_q ? S_FETCH : S_WB;
                    else if (timeout) state_d = S_ERROR;
                end
                S_WB:     state_d = S_FETCH;
                S_HALTED: state_d = S_HALTED;
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_FETCH;
            endcase

            // Count only stalled cycles within one state. A completion or any
            // state change restarts the count.
            if (bus_req && waitrequest && (state_d == state_q))
                wait_cnt_d = wait_cnt_q + 1'b1;
            else
                wait_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: requests follow the state alone, so they stay stable
    // while frozen. Strobes also need an enabled cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        active         = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr_sel       = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        reg_write_gate = 1'b0;
        data_latch     = 1'b0;
        bus_error      = 1'b0;

        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    active   = 1'b1;
                    mem_read = fetch_req;
                    ir_write = fetch_req && clk_enable && !waitrequest;
                end
                S_EXEC: begin
                    active         = 1'b1;
                    pc_write       = clk_enable && !(is_load || is_store);
                    reg_write_gate = clk_enable && !(is_load || is_store);
                end
                S_MEM: begin
                    active     = 1'b1;
                    addr_sel   = 1'b1;
                    mem_read   = !store_q;
                    mem_write  = store_q;
                    pc_write   = clk_enable && !waitrequest && store_q;
                    data_latch = clk_enable && !waitrequest && !store_q;
                end
                S_WB: begin
                    active         = 1'b1;
                    reg_write_gate = clk_enable;
                    pc_write       = clk_enable;
                end
                S_HALTED: ;
                S_ERROR:  bus_error = 1'b1;
                default:  active    = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_bus_controller
//
// Self-checking bench for mips_bus_controller (MAX_WAIT overridden to 4).
// A table of directed vectors covers the main instruction flows. Hand-written
// sequences cover halt, timeout and mid-transfer reset. A randomized phase is
// then checked against an instruction-level reference model. That model keeps
// a queue of the remaining steps of the current instruction.
// -----------------------------------------------------------------------------
module tb_mips_bus_controller;

    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] P        = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        waitrequest;
    logic [31:0] pc;
    logic        is_load;
    logic        is_store;
    logic        active, mem_read, mem_write, addr_sel;
    logic        ir_write, pc_write, reg_write_gate, data_latch, bus_error;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_bus_controller #(
        .HALT_ADDR (32'h0000_0000),
        .WAIT_W    (8),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .waitrequest    (waitrequest),
        .pc             (pc),
        .is_load        (is_load),
        .is_store       (is_store),
        .active         (active),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr_sel       (addr_sel),
        .ir_write       (ir_write),
        .pc_write       (pc_write),
        .reg_write_gate (reg_write_gate),
        .data_latch     (data_latch),
        .bus_error      (bus_error),
        .state          (state)
    );

    // {state, active, mem_read, mem_write, addr_sel, ir_write, pc_write,
    //  reg_write_gate, data_latch, bus_error}
    logic [11:0] dut_out;
    assign dut_out = {state, active, mem_read, mem_write, addr_sel, ir_write,
                      pc_write, reg_write_gate, data_latch, bus_error};

    function automatic logic [11:0] ex(int s, bit act, bit rd, bit wr, bit as,
                                       bit ir, bit pcw, bit rwg, bit dl, bit be);
        logic [2:0] s3;
        s3 = s[2:0];
        return {s3, act, rd, wr, as, ir, pcw, rwg, dl, be};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d bits=%b, expected st=%0d bits=%b",
                     name, act[11:9], act[8:0], exp[11:9], exp[8:0]);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and compare the outputs
    // after they settle.
    task automatic step(input bit en, input bit wr, input logic [31:0] p,
                        input bit ld, input bit st, input logic [11:0] exp,
                        input string name);
        @(negedge clk);
        clk_enable  = en;
        waitrequest = wr;
        pc          = p;
        is_load     = ld;
        is_store    = st;
        #1 check(name, dut_out, exp);
    endtask

    // Assert reset away from the clock edge. While reset is high, all outputs
    // must read 0. Release with clk_enable low so the FSM waits in FETCH.
    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        #1 check(name, dut_out, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset      = 1'b0;
        clk_enable = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: the remaining steps of the current instruction.
    // An empty queue means the model is fetching.
    // ------------------------------------------------------------------
    typedef enum { ST_EXEC, ST_RD, ST_WR, ST_WB } step_e;
    step_e steps[$];
    int    stalls;      // stalled enabled cycles on the current transfer
    int    dead;        // 0 running, 1 halted, 2 bus error

    function automatic logic [11:0] model_out(bit en, bit wr, logic [31:0] p, bit ld, bit st);
        bit alu;
        if (dead == 1) return ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (dead == 2) return ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (steps.size() == 0) begin
            if (p == 32'h0) return ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            return ex(0, 1, 1, 0, 0, en && !wr, 0, 0, 0, 0);
        end
        alu = !(ld || st);
        case (steps[0])
            ST_EXEC: return ex(1, 1, 0, 0, 0, 0, en && alu, en && alu, 0, 0);
            ST_RD:   return ex(2, 1, 1, 0, 1, 0, 0, 0, en && !wr, 0);
            ST_WR:   return ex(2, 1, 0, 1, 1, 0, en && !wr, 0, 0, 0);
            default: return ex(3, 1, 0, 0, 0, 0, en, en, 0, 0);
        endcase
    endfunction

    task automatic model_advance(input bit en, input bit wr, input logic [31:0] p,
                                 input bit ld, input bit st);
        bit    on_bus;
        step_e s;
        if (!en || dead != 0) return;
        if (steps.size() == 0 && p == 32'h0) begin
            dead = 1;
            return;
        end
        on_bus = (steps.size() == 0) || (steps[0] == ST_RD) || (steps[0] == ST_WR);
        if (on_bus && wr) begin
            if (stalls == MAX_WAIT) begin
                dead = 2;
                steps.delete();
                stalls = 0;
            end else begin
                stalls++;
            end
            return;
        end
        stalls = 0;
        if (steps.size() == 0) begin
            steps.push_back(ST_EXEC);
        end else begin
            s = steps.pop_front();
            if (s == ST_EXEC) begin
                if (ld) begin
                    steps.push_back(ST_RD);
                    steps.push_back(ST_WB);
                end else if (st) begin
                    steps.push_back(ST_WR);
                end
            end
        end
    endtask

    task automatic model_reset();
        steps.delete();
        stalls = 0;
        dead   = 0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          en;
        bit          wr;
        logic [31:0] p;
        bit          ld;
        bit          st;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit en, input bit wr, input logic [31:0] p, input bit ld,
                       input bit st, input logic [11:0] exp, input string name);
        vec_t v;
        v.en = en; v.wr = wr; v.p = p; v.ld = ld; v.st = st; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin : main
        logic [11:0] f_done, f_frz, e_alu, e_mem, m_rd_stall, m_rd_done, m_rd_frz, m_wr_done, wb, halted;
        int          bias;
        bit          en, wr, ld, st;
        logic [31:0] p;
        logic [11:0] exp;

        f_done     = ex(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        f_frz      = ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        e_alu      = ex(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        e_mem      = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        m_rd_stall = ex(2, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        m_rd_done  = ex(2, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        m_rd_frz   = m_rd_stall;
        m_wr_done  = ex(2, 1, 0, 1, 1, 0, 1, 0, 0, 0);
        wb         = ex(3, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        halted     = ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Two ALU instructions, 2 cycles each.
        add(1, 0, P, 0, 0, f_done, "alu0_fetch");
        add(1, 0, P, 0, 0, e_alu,  "alu0_exec");
        add(1, 0, P, 0, 0, f_done, "alu1_fetch");
        add(1, 0, P, 0, 0, e_alu,  "alu1_exec");
        // Load with 3 stall cycles in MEM. Decoder flags change afterwards;
        // the captured transfer kind must hold.
        add(1, 0, P, 0, 0, f_done,     "ld_fetch");
        add(1, 0, P, 1, 0, e_mem,      "ld_exec");
        add(1, 1, P, 0, 0, m_rd_stall, "ld_stall1");
        add(1, 1, P, 0, 1, m_rd_stall, "ld_stall2");
        add(1, 1, P, 0, 0, m_rd_stall, "ld_stall3");
        add(1, 0, P, 0, 1, m_rd_done,  "ld_done");
        add(1, 0, P, 0, 0, wb,         "ld_wb");
        // Store, 3 cycles.
        add(1, 0, P, 0, 0, f_done,    "st_fetch");
        add(1, 0, P, 0, 1, e_mem,     "st_exec");
        add(1, 0, P, 0, 0, m_wr_done, "st_done");
        // Load and store both high: treated as a load.
        add(1, 0, P, 0, 0, f_done,    "both_fetch");
        add(1, 0, P, 1, 1, e_mem,     "both_exec");
        add(1, 0, P, 0, 0, m_rd_done, "both_mem");
        add(1, 0, P, 0, 0, wb,        "both_wb");
        // Freeze for 3 cycles in MEM while the memory is ready.
        add(1, 0, P, 0, 0, f_done,    "frz_fetch");
        add(1, 0, P, 1, 0, e_mem,     "frz_exec");
        add(0, 0, P, 0, 0, m_rd_frz,  "frz_mem1");
        add(0, 0, P, 0, 0, m_rd_frz,  "frz_mem2");
        add(0, 0, P, 0, 0, m_rd_frz,  "frz_mem3");
        add(1, 0, P, 0, 0, m_rd_done, "frz_mem_go");
        add(1, 0, P, 0, 0, wb,        "frz_wb");
        // Freeze in FETCH, then resume.
        add(0, 0, P, 0, 0, f_frz,  "frz_fetch");
        add(1, 0, P, 0, 0, f_done, "frz_fetch_go");
        add(1, 0, P, 0, 0, e_alu,  "frz_fetch_exec");
        // Halt address.
        add(1, 0, 32'h0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "halt_fetch");
        add(1, 1, 32'h0, 0, 0, halted, "halt_enter");

        reset = 1'b1; clk_enable = 1'b0; waitrequest = 1'b0;
        pc = P; is_load = 1'b0; is_store = 1'b0;
        model_reset();

        do_reset("reset_outputs");

        foreach (tbl[i])
            step(tbl[i].en, tbl[i].wr, tbl[i].p, tbl[i].ld, tbl[i].st, tbl[i].exp, tbl[i].name);

        // HALTED holds for 10 cycles, whatever the bus and PC do.
        for (int i = 0; i < 10; i++)
            step(1, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
                 1'($urandom_range(1)), halted, "halt_hold");

        // Timeout: waitrequest stuck high in FETCH with MAX_WAIT=4.
        do_reset("reset_from_halt");
        for (int i = 0; i < 5; i++)
            step(1, 1, P, 0, 0, f_frz, "to_wait");
        step(1, 1, P, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1), "to_error");
        step(1, 0, P, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1), "to_error_hold");
        do_reset("reset_from_error");
        step(1, 0, P, 0, 0, f_done, "after_error_reset");

        // Reset asserted in the middle of a stalled load transfer.
        step(1, 1, P, 1, 0, e_alu & 12'h000 | ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mid_exec");
        step(1, 1, P, 0, 0, m_rd_stall, "mid_mem");
        do_reset("reset_mid_transfer");

        // Randomized run against the reference model.
        model_reset();
        bias = 30;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 60 == 0) bias = ($urandom_range(3) == 0) ? 85 : 25;
            if ((dead != 0 && $urandom_range(7) == 0) || $urandom_range(199) == 0) begin
                do_reset("rand_reset");
                model_reset();
            end else begin
                en = ($urandom_range(9) != 0);
                wr = ($urandom_range(99) < bias);
                p  = ($urandom_range(24) == 0) ? 32'h0 : ($urandom | 32'h4);
                ld = 1'($urandom_range(1));
                st = 1'($urandom_range(1));
                exp = model_out(en, wr, p, ld, st);
                step(en, wr, p, ld, st, exp, "rand");
                @(posedge clk);
                model_advance(en, wr, p, ld, st);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_controller.md
Name: mips_bus_controller

Overview:
- Multi-cycle sequencer for the bus variant of the MIPS CPU: one shared Avalon-style memory port carries both instruction fetch and load/store data.
- Steps the existing datapath (pc, decoder, register_file, ALU) through FETCH -> EXEC -> MEM -> WB.
- Generates the gating strobes that replace the single-cycle Harvard enables, plus the bus request handshake, halt detection and bus-timeout error.

Parameters:
- HALT_ADDR, 32'h00000000, fetch address that terminates execution.
- WAIT_W, 8, width of the waitrequest timeout counter.
- MAX_WAIT, 255, consecutive waitrequest cycles tolerated per transfer; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  1 = advance; 0 = freeze the FSM.
- waitrequest  in  1  memory stall; the transfer completes in a cycle where the request is high and waitrequest is 0.
- pc  in  32  current PC from the pc register.
- is_load  in  1  decoder: current instruction is a load (valid in EXEC).
- is_store  in  1  decoder: current instruction is a store (valid in EXEC).
- active  out  1  CPU running.
- mem_read  out  1  bus read request.
- mem_write  out  1  bus write request.
- addr_sel  out  1  bus address mux: 0 = pc, 1 = ALU result.
- ir_write  out  1  latch instruction register (1-cycle pulse).
- pc_write  out  1  PC update strobe (1-cycle pulse).
- reg_write_gate  out  1  allow register_file write this cycle.
- data_latch  out  1  latch load data register (1-cycle pulse).
- bus_error  out  1  sticky timeout flag.
- state  out  3  FSM state, for debug and bench.

Behaviour:
- State encoding: FETCH=0, EXEC=1, MEM=2, WB=3, HALTED=4, ERROR=5. Values 6-7 are unreachable; if entered, go to FETCH.
- Reset (async, asynchronous assert): state=FETCH, wait counter=0, bus_error=0.
  - While reset is high, every output except state is forced 0.
  - After release: active=1.
- FETCH, pc==HALT_ADDR: no request; next state HALTED.
- FETCH, otherwise:
  - mem_read=1, addr_sel=0.
  - When waitrequest=0: ir_write=1, next state EXEC.
  - Else stay in FETCH.
- EXEC (exactly 1 cycle, no bus request):
  - is_load -> MEM (read).
  - is_store -> MEM (write).
  - Neither -> pc_write=1, reg_write_gate=1, next state FETCH.
  - is_load and is_store both high: treat as load.
- MEM:
  - addr_sel=1; mem_read=1 for a load or mem_write=1 for a store. The kind is captured in EXEC and held stable for the whole MEM state.
  - Load completing (waitrequest=0): data_latch=1, next state WB.
  - Store completing: pc_write=1, next state FETCH.
- WB (1 cycle): reg_write_gate=1, pc_write=1, next state FETCH.
- HALTED: active=0, no requests, no strobes. Only reset exits.
- ERROR: active=0, bus_error=1, no requests, no strobes. Only reset exits.
- Timeout counter (WAIT_W bits):
  - Increments each enabled cycle with a request high and waitrequest=1.
  - Cleared on transfer completion and on every state change.
  - MAX_WAIT!=0, counter==MAX_WAIT and waitrequest=1: next state ERROR, request dropped next cycle.
- clk_enable=0:
  - State and counter hold.
  - ir_write, pc_write, reg_write_gate and data_latch are forced 0.
  - mem_read, mem_write and addr_sel keep their current-state values, so the bus request stays stable.
  - A completion seen while clk_enable=0 is ignored; the request stays asserted until an enabled cycle.
- Strobes are combinational from state plus inputs. Every strobe pulses for exactly one cycle per instruction.
- Throughput with waitrequest=0 throughout:
  - ALU/branch instruction: 2 cycles.
  - Store: 3 cycles.
  - Load: 4 cycles.
- Reset asserted mid-transfer: requests drop immediately (asynchronous); no strobe fires.

Test Plan:
- Reset, pc=32'hBFC00000, waitrequest=0, is_load=is_store=0 -> state 0,1,0,1…; ir_write and pc_write alternate; one pc_write every 2 cycles; active=1.
- Load, waitrequest=1 for 3 cycles in MEM -> mem_read=1 and addr_sel=1 held 4 cycles; data_latch at cycle 4; WB asserts reg_write_gate and pc_write once.
- Store -> mem_write=1 in MEM; no data_latch; no reg_write_gate; pc_write on completion; back to FETCH.
- pc=32'h00000000 on FETCH -> mem_read stays 0; state=4 next cycle; active=0; held for 10 cycles regardless of waitrequest.
- MAX_WAIT=4, waitrequest stuck at 1 in FETCH -> ERROR after 5 cycles of request; bus_error=1, active=0; reset clears both.
- clk_enable=0 for 3 cycles mid-MEM with waitrequest=0 -> state frozen at 2, mem_read held, no strobes; completes on the first enabled cycle.
